// File: rtl/pi_velocity_ctrl_if.sv
// pi_velocity_ctrl_if
// Handshake and data bundle between the velocity-loop sequencer and the PI
// velocity controller.
//   master : drives enable, clear_integrator, desired/actual velocity, kp, ki;
//            receives output_gain, out_valid, busy, saturated, overrun.
//   slave  : the controller side (mirror of master).
interface pi_velocity_ctrl_if #(
    parameter int VEL_W  = 16,
    parameter int GAIN_W = 14,
    parameter int OUT_W  = 11
);
    logic                     enable;
    logic                     clear_integrator;
    logic signed [VEL_W-1:0]  desired_velocity;
    logic signed [VEL_W-1:0]  actual_velocity;
    logic signed [GAIN_W-1:0] kp;
    logic signed [GAIN_W-1:0] ki;
    logic signed [OUT_W-1:0]  output_gain;
    logic                     out_valid;
    logic                     busy;
    logic                     saturated;
    logic                     overrun;

    modport master (
        output enable, clear_integrator, desired_velocity, actual_velocity, kp, ki,
        input  output_gain, out_valid, busy, saturated, overrun
    );

    modport slave (
        input  enable, clear_integrator, desired_velocity, actual_velocity, kp, ki,
        output output_gain, out_valid, busy, saturated, overrun
    );
endinterface

// File: rtl/pi_velocity_ctrl.sv
// pi_velocity_ctrl
// Multi-cycle PI velocity controller for the BLDC loop. An enable pulse in
// IDLE samples the inputs; the error is integrated (saturating), kp*err and
// ki*acc are formed on one shared multiplier, summed, arithmetically shifted
// right by SHIFT and clamped to +/-(2^(OUT_W-1)-1).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pi_velocity_ctrl_if.slave (enable, clear_integrator,
//                desired/actual velocity, kp, ki in; output_gain, out_valid,
//                busy, saturated, overrun out)
// Build option: PI_COND_INTEG_EN enables conditional integration
// (anti-windup) - the integrator holds while the previous result was clamped
// and the new error pushes further in the same direction.
//
// state  | meaning
// IDLE   | waiting for enable; latches gains and error on enable
// ERR    | integrator update
// MUL_P  | p = kp * err
// MUL_I  | i = ki * acc (post-update accumulator)
// SUM    | shift, clamp, register result and pulse out_valid
module pi_velocity_ctrl #(
    parameter int VEL_W  = 16,
    parameter int GAIN_W = 14,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 11,
    parameter int SHIFT  = 21
) (
    input logic              clk,
    input logic              reset,
    pi_velocity_ctrl_if.slave bus
);
    localparam int ERR_W = VEL_W + 1;
    localparam int B_W   = (ACC_W > ERR_W) ? ACC_W : ERR_W;
    localparam int M_W   = GAIN_W + B_W;
    localparam int P_W   = GAIN_W + ERR_W;
    localparam int I_W   = GAIN_W + ACC_W;
    localparam int S_W   = GAIN_W + ACC_W + 1;

    localparam logic signed [ACC_W:0] ACC_HI = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_LO = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
    localparam logic signed [S_W-1:0] OUT_HI = {{(S_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] OUT_LO = {{(S_W-OUT_W+1){1'b1}}, {(OUT_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_SUM} state_t;
    state_t state, state_nx;

    logic signed [GAIN_W-1:0] kp_r, ki_r;
    logic signed [ERR_W-1:0]  err_r;
    logic signed [ACC_W-1:0]  acc;
    logic signed [P_W-1:0]    p_r;
    logic signed [I_W-1:0]    i_r;
    logic signed [OUT_W-1:0]  gain_r;
    logic                     valid_r, sat_r, overrun_r;

    logic signed [GAIN_W-1:0] mul_a;
    logic signed [B_W-1:0]    mul_b;
    logic signed [M_W-1:0]    mul_y;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_nx;
    logic signed [S_W-1:0]    s_sum, q_full;
    logic signed [OUT_W-1:0]  gain_nx;
    logic                     sat_nx;
    logic                     hold;

`ifdef PI_COND_INTEG_EN
    // Stop winding up while the output is pinned and the error keeps pushing it.
    assign hold = sat_r && (err_r != '0) && (err_r[ERR_W-1] == gain_r[OUT_W-1]);
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.enable) state_nx = S_ERR;
            S_ERR:   state_nx = S_MUL_P;
            S_MUL_P: state_nx = S_MUL_I;
            S_MUL_I: state_nx = S_SUM;
            S_SUM:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        // Shared multiplier: kp*err in MUL_P, ki*acc in MUL_I.
        mul_a = kp_r;
        mul_b = B_W'(err_r);
        if (state == S_MUL_I) begin
            mul_a = ki_r;
            mul_b = B_W'(acc);
        end
        mul_y = M_W'(mul_a) * M_W'(mul_b);

        acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(err_r);
        if (acc_sum > ACC_HI)
            acc_nx = ACC_HI[ACC_W-1:0];
        else if (acc_sum < ACC_LO)
            acc_nx = ACC_LO[ACC_W-1:0];
        else
            acc_nx = acc_sum[ACC_W-1:0];

        s_sum  = S_W'(p_r) + S_W'(i_r);
        q_full = s_sum >>> SHIFT;
        sat_nx = 1'b0;
        if (q_full > OUT_HI) begin
            gain_nx = OUT_HI[OUT_W-1:0];
            sat_nx  = 1'b1;
        end else if (q_full < OUT_LO) begin
            gain_nx = OUT_LO[OUT_W-1:0];
            sat_nx  = 1'b1;
        end else begin
            gain_nx = q_full[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            kp_r      <= '0;
            ki_r      <= '0;
            err_r     <= '0;
            acc       <= '0;
            p_r       <= '0;
            i_r       <= '0;
            gain_r    <= '0;
            valid_r   <= 1'b0;
            sat_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        kp_r  <= bus.kp;
                        ki_r  <= bus.ki;
                        err_r <= ERR_W'(bus.desired_velocity) - ERR_W'(bus.actual_velocity);
                    end
                end
                S_ERR:   if (!hold) acc <= acc_nx;
                S_MUL_P: p_r <= mul_y[P_W-1:0];
                S_MUL_I: i_r <= mul_y[I_W-1:0];
                S_SUM: begin
                    gain_r  <= gain_nx;
                    sat_r   <= sat_nx;
                    valid_r <= 1'b1;
                end
                default: ;
            endcase
            if (bus.enable && (state != S_IDLE))
                overrun_r <= 1'b1;
            // Clear wins over the ERR update and over a same-cycle overrun.
            if (bus.clear_integrator) begin
                acc       <= '0;
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.output_gain = gain_r;
    assign bus.out_valid   = valid_r;
    assign bus.saturated   = sat_r;
    assign bus.overrun     = overrun_r;
    assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_pi_velocity_ctrl.sv
module tb_pi_velocity_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pi_velocity_ctrl_if bus ();
    pi_velocity_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        longint gain;
        longint sat;
    } exp_t;
    exp_t sb[$];

    longint m_acc, m_gain, m_sat;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input longint d, input longint a, input longint kp, input longint ki);
        longint err, nacc, p, i, s, q;
        bit hold;
        exp_t e;
        err  = d - a;
        hold = 1'b0;
`ifdef PI_COND_INTEG_EN
        hold = (m_sat == 1) && (err != 0) && ((err < 0) == (m_gain < 0));
`endif
        if (!hold) begin
            nacc = m_acc + err;
            if (nacc > 8388607) nacc = 8388607;
            if (nacc < -8388607) nacc = -8388607;
            m_acc = nacc;
        end
        p = kp * err;
        i = ki * m_acc;
        s = p + i;
        q = s >>> 21;
        if (q > 1023) begin
            e.gain = 1023; e.sat = 1;
        end else if (q < -1023) begin
            e.gain = -1023; e.sat = 1;
        end else begin
            e.gain = q; e.sat = 0;
        end
        m_gain = e.gain;
        m_sat  = e.sat;
        sb.push_back(e);
    endfunction

    task automatic drive(input int d, input int a, input int kp, input int ki);
        bus.desired_velocity = 16'(d);
        bus.actual_velocity  = 16'(a);
        bus.kp               = 14'(kp);
        bus.ki               = 14'(ki);
    endtask

    task automatic run_update(input int d, input int a, input int kp, input int ki);
        int cyc;
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        drive(d, a, kp, ki);
        bus.enable = 1'b1;
        model_push(d, a, kp, ki);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        // later input changes must not affect the result
        drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        check("busy_after_enable", longint'(bus.busy), 1);
        cyc = 0;
        while (!bus.out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_seen", longint'(bus.out_valid), 1);
        check("latency", cyc, 4);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (bus.out_valid) begin
                check("output_gain", longint'(bus.output_gain), e.gain);
                check("saturated", longint'(bus.saturated), e.sat);
            end
        end
        @(posedge clk); #1;
        check("out_valid_drop", longint'(bus.out_valid), 0);
        check("busy_drop", longint'(bus.busy), 0);
    endtask

    task automatic clear_acc();
        @(negedge clk);
        bus.clear_integrator = 1'b1;
        @(posedge clk); #1;
        bus.clear_integrator = 1'b0;
        m_acc = 0;
        check("overrun_after_clear", longint'(bus.overrun), 0);
        check("acc_after_clear", longint'(dut.acc), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, extra;
        exp_t e;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.clear_integrator = 1'b0;
        drive(0, 0, 0, 0);
        m_acc = 0; m_gain = 0; m_sat = 0;

        @(posedge clk); #1;
        check("rst_gain", longint'(bus.output_gain), 0);
        check("rst_valid", longint'(bus.out_valid), 0);
        check("rst_sat", longint'(bus.saturated), 0);
        check("rst_overrun", longint'(bus.overrun), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_acc", longint'(dut.acc), 0);

        // proportional only, positive and negative (floor)
        run_update(1000, 0, 8191, 0);
        check("p_only_gain", longint'(bus.output_gain), 3);
        run_update(0, 1000, 8191, 0);
        check("p_neg_floor_gain", longint'(bus.output_gain), -4);
        // mixed P and I
        run_update(-2000, 500, 3000, -4000);
        run_update(12345, -20000, -8192, 8191);

        // overrun: second enable two edges later is ignored
        clear_acc();
        @(negedge clk);
        drive(500, 0, 8191, 0);
        bus.enable = 1'b1;
        model_push(500, 0, 8191, 0);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive(-30000, 30000, 8191, 8191);
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        check("overrun_set", longint'(bus.overrun), 1);
        cyc = 2;
        while (!bus.out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ovr_latency", cyc, 4);
        e = sb.pop_front();
        check("ovr_gain", longint'(bus.output_gain), e.gain);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        check("ovr_single_valid", extra, 0);
        check("overrun_sticky", longint'(bus.overrun), 1);
        clear_acc();

        // accumulator positive limit, no wrap
        for (int k = 0; k < 257; k++) run_update(32767, 0, 0, 0);
        check("acc_limit", longint'(dut.acc), 8388607);
        clear_acc();

        // output clamp sequence
        for (int k = 1; k <= 10; k++) begin
            run_update(32767, 0, 0, 8191);
            if (k == 8) begin
                check("clamp8_acc", longint'(dut.acc), 262136);
                check("clamp8_gain", longint'(bus.output_gain), 1023);
                check("clamp8_sat", longint'(bus.saturated), 0);
            end
            if (k == 9) begin
                check("clamp9_acc", longint'(dut.acc), 294903);
                check("clamp9_gain", longint'(bus.output_gain), 1023);
                check("clamp9_sat", longint'(bus.saturated), 1);
            end
        end
`ifdef PI_COND_INTEG_EN
        check("clamp10_acc", longint'(dut.acc), 294903);
`else
        check("clamp10_acc", longint'(dut.acc), 327670);
`endif

        // reset in the middle of an update
        @(negedge clk);
        drive(1000, 0, 8191, 0);
        bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_acc = 0; m_gain = 0; m_sat = 0;
        check("midrst_gain", longint'(bus.output_gain), 0);
        check("midrst_sat", longint'(bus.saturated), 0);
        check("midrst_busy", longint'(bus.busy), 0);
        check("midrst_valid", longint'(bus.out_valid), 0);
        check("midrst_acc", longint'(dut.acc), 0);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        check("midrst_no_valid", extra, 0);
        // enable at the first edge after reset release
        run_update(-1000, 0, 8191, 0);
        check("post_rst_gain", longint'(bus.output_gain), -4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
